// File: rtl/seg_scan4_if.sv
// seg_scan4_if -- display bus between the washer controller and the
// four-digit seven-segment scanner.
//   dig0..dig3  4-bit display codes (digit X is shown while ena[X] is high)
//   blink_mask  bit X set makes digit X blink
//   dp          decimal-point request per digit (only when SCAN_DP_EN is defined)
//   ena         one-hot (or zero) digit enables, active-high
//   led         segments a..g on led[7:1], decimal point on led[0]
// Modports: master = code source / display observer, slave = scanner.
interface seg_scan4_if;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] blink_mask;
`ifdef SCAN_DP_EN
  logic [3:0] dp;
`endif
  logic [3:0] ena;
  logic [7:0] led;

  modport master (
    output dig0, dig1, dig2, dig3, blink_mask,
`ifdef SCAN_DP_EN
    output dp,
`endif
    input  ena, led
  );

  modport slave (
    input  dig0, dig1, dig2, dig3, blink_mask,
`ifdef SCAN_DP_EN
    input  dp,
`endif
    output ena, led
  );
endinterface

// File: rtl/seg_scan4.sv
// seg_scan4 -- four-digit multiplexed seven-segment driver for the washer
// front panel.
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  seg_scan4_if.slave: dig0..dig3, blink_mask, dp (optional) in;
//        ena, led out
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLINK_DIV    clk cycles per blink half-period (>= 2)
// Optional feature: define SCAN_DP_EN to enable the per-digit decimal point;
// without it led[0] is always 0 and no dp shadow exists.
//
// A snapshot of codes/mask/dp is latched once per frame (on the slot 3 -> 0
// tick) so a frame is never torn by mid-frame input changes.
module seg_scan4 #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan4_if.slave  bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;
  logic          bph;
  logic [1:0]    idx;
  logic [3:0]    sh0, sh1, sh2, sh3;
  logic [3:0]    shmask;
`ifdef SCAN_DP_EN
  logic [3:0]    shdp;
`endif
  logic [3:0]    ena_r;
  logic [7:0]    led_r;

  logic          tick;
  logic          bwrap;
  logic          frame;
  logic          bph_nxt;
  logic [1:0]    idx_nxt;
  logic [3:0]    code;
  logic          mask_bit;
  logic          dp_bit;
  logic [3:0]    ena_nxt;
  logic [7:0]    led_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd10:   s = 7'b0111101;
      4'd12:   s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick    = (rcnt == R_LAST);
  assign bwrap   = (bcnt == B_LAST);
  assign frame   = tick && (idx == 2'd3);
  assign idx_nxt = idx + 2'd1;
  // A blink toggle landing on the same edge as a tick already applies.
  assign bph_nxt = bwrap ? ~bph : bph;

  // On a frame-boundary tick the shadows are being loaded this very edge,
  // so take the values straight from the inputs.
  always_comb begin
    code     = 4'd11;
    mask_bit = 1'b0;
    dp_bit   = 1'b0;
    if (frame) begin
      case (idx_nxt)
        2'd0:    code = bus.dig0;
        2'd1:    code = bus.dig1;
        2'd2:    code = bus.dig2;
        default: code = bus.dig3;
      endcase
      mask_bit = bus.blink_mask[idx_nxt];
`ifdef SCAN_DP_EN
      dp_bit   = bus.dp[idx_nxt];
`endif
    end else begin
      case (idx_nxt)
        2'd0:    code = sh0;
        2'd1:    code = sh1;
        2'd2:    code = sh2;
        default: code = sh3;
      endcase
      mask_bit = shmask[idx_nxt];
`ifdef SCAN_DP_EN
      dp_bit   = shdp[idx_nxt];
`endif
    end
    ena_nxt = 4'b0001 << idx_nxt;
    if (mask_bit && !bph_nxt)
      led_nxt = 8'h00;
    else
      led_nxt = {seg_decode(code), dp_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      bcnt <= '0;
      bph  <= 1'b1;
      idx  <= 2'd3;
    end else begin
      rcnt <= tick  ? '0 : rcnt + 1'b1;
      bcnt <= bwrap ? '0 : bcnt + 1'b1;
      bph  <= bph_nxt;
      if (tick)
        idx <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0    <= 4'd11;
      sh1    <= 4'd11;
      sh2    <= 4'd11;
      sh3    <= 4'd11;
      shmask <= 4'b0000;
`ifdef SCAN_DP_EN
      shdp   <= 4'b0000;
`endif
    end else if (frame) begin
      sh0    <= bus.dig0;
      sh1    <= bus.dig1;
      sh2    <= bus.dig2;
      sh3    <= bus.dig3;
      shmask <= bus.blink_mask;
`ifdef SCAN_DP_EN
      shdp   <= bus.dp;
`endif
    end
  end

  // ena and led share one register stage so they always switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_r <= 4'b0000;
      led_r <= 8'h00;
    end else if (tick) begin
      ena_r <= ena_nxt;
      led_r <= led_nxt;
    end
  end

  assign bus.ena = ena_r;
  assign bus.led = led_r;

endmodule
